// File: rtl/snake_engine.sv
// snake_engine: snake body shift register, tick-paced movement, growth, self-collision and render queries
module snake_engine #(
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int X_BITS   = 8,
  parameter int Y_BITS   = 7,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int LEN_BITS = 6,
  parameter int TICK_DIV = 5000000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          DIR,
  input  logic                ENABLE,
  input  logic                GROW,
  input  logic [X_BITS-1:0]   QUERY_X,
  input  logic [Y_BITS-1:0]   QUERY_Y,
  output logic [X_BITS-1:0]   HEAD_X,
  output logic [Y_BITS-1:0]   HEAD_Y,
  output logic [LEN_BITS-1:0] LENGTH,
  output logic                MOVE_TICK,
  output logic                COLLISION,
  output logic                PIXEL_HIT,
  output logic                HEAD_HIT
);
  localparam int C_BITS = $clog2(TICK_DIV);
  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);
  typedef enum logic {RUN, DEAD} state_t;
  state_t state, state_nxt;
  logic [X_BITS-1:0] seg_x [MAX_LEN];
  logic [Y_BITS-1:0] seg_y [MAX_LEN];
  logic [C_BITS-1:0] cnt;
  logic grow_pending, grow, hit, move, pix;
  logic [X_BITS-1:0] nx;
  logic [Y_BITS-1:0] ny;
  logic [LEN_BITS-1:0] lim;
  assign MOVE_TICK = cnt == C_BITS'(TICK_DIV - 1);
  assign COLLISION = state == DEAD;
  assign HEAD_X = seg_x[0];
  assign HEAD_Y = seg_y[0];
  // next head with wrap, collision search over the body that stays put, query match and next state
  always_comb begin
    nx = DIR == 2'b01 ? (seg_x[0] == X_MAX ? '0 : seg_x[0] + X_BITS'(1)) :
         DIR == 2'b11 ? (seg_x[0] == '0 ? X_MAX : seg_x[0] - X_BITS'(1)) : seg_x[0];
    ny = DIR == 2'b10 ? (seg_y[0] == Y_MAX ? '0 : seg_y[0] + Y_BITS'(1)) :
         DIR == 2'b00 ? (seg_y[0] == '0 ? Y_MAX : seg_y[0] - Y_BITS'(1)) : seg_y[0];
    grow = grow_pending | GROW;
    lim = grow ? LENGTH - LEN_BITS'(1) : LENGTH - LEN_BITS'(2);
    move = state == RUN && MOVE_TICK && ENABLE;
    hit = 1'b0;
    pix = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      hit |= k > 0 && LEN_BITS'(k) <= lim && seg_x[k] == nx && seg_y[k] == ny;
      pix |= LEN_BITS'(k) < LENGTH && seg_x[k] == QUERY_X && seg_y[k] == QUERY_Y;
    end
    state_nxt = move && hit ? DEAD : state;
  end
  // state register and free-running move tick counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= MOVE_TICK ? '0 : cnt + C_BITS'(1);
    end
  end
  // body shift on a clean move, growth bookkeeping
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_BITS'(GRID_W / 2);
        seg_y[i] <= Y_BITS'(GRID_H / 2 + i);
      end
      LENGTH <= LEN_BITS'(INIT_LEN);
      grow_pending <= 1'b0;
    end else if (move && !hit) begin
      for (int i = MAX_LEN - 1; i > 0; i--) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
      seg_x[0] <= nx;
      seg_y[0] <= ny;
      if (grow && LENGTH != LEN_BITS'(MAX_LEN)) LENGTH <= LENGTH + LEN_BITS'(1);
      if (grow) grow_pending <= 1'b0;
    end else if (GROW && state == RUN) begin
      grow_pending <= 1'b1;
    end
  end
  // registered render query answers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PIXEL_HIT <= 1'b0;
      HEAD_HIT <= 1'b0;
    end else begin
      PIXEL_HIT <= pix;
      HEAD_HIT <= seg_x[0] == QUERY_X && seg_y[0] == QUERY_Y;
    end
  end
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed and random stimulus checked against a coordinate-list model of the snake
module tb_snake_engine;
  localparam int W = 160, H = 120, MAXL = 32, T = 4;
  logic CLK = 0, RESET = 0, ENABLE = 1, GROW = 0;
  logic [1:0] DIR = 0;
  logic [7:0] QUERY_X = 80;
  logic [6:0] QUERY_Y = 63;
  logic [7:0] HEAD_X;
  logic [6:0] HEAD_Y;
  logic [5:0] LENGTH;
  logic MOVE_TICK, COLLISION, PIXEL_HIT, HEAD_HIT;
  int checks = 0, errors = 0;
  int mx[MAXL], my[MAXL];
  int mlen, mcnt;
  bit mpend, mdead, epix, ehead;

  snake_engine #(.TICK_DIV(T)) dut (
    .CLK(CLK), .RESET(RESET), .DIR(DIR), .ENABLE(ENABLE), .GROW(GROW),
    .QUERY_X(QUERY_X), .QUERY_Y(QUERY_Y), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y),
    .LENGTH(LENGTH), .MOVE_TICK(MOVE_TICK), .COLLISION(COLLISION),
    .PIXEL_HIT(PIXEL_HIT), .HEAD_HIT(HEAD_HIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < MAXL; i++) begin
      mx[i] = W / 2;
      my[i] = H / 2 + i;
    end
    mlen = 4; mcnt = 0; mpend = 0; mdead = 0; epix = 0; ehead = 0;
  endtask

  // reference model: snake as a list of coordinates, advanced by the movement rules
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) mreset();
    else begin
      bit g, h, tick;
      int nx, ny, lim;
      tick = mcnt == T - 1;
      g = mpend || GROW;
      epix = 0;
      for (int k = 0; k < mlen; k++) if (mx[k] == QUERY_X && my[k] == QUERY_Y) epix = 1;
      ehead = mx[0] == QUERY_X && my[0] == QUERY_Y;
      if (!mdead && tick && ENABLE) begin
        nx = (mx[0] + (DIR == 1 ? 1 : DIR == 3 ? -1 : 0) + W) % W;
        ny = (my[0] + (DIR == 2 ? 1 : DIR == 0 ? -1 : 0) + H) % H;
        lim = g ? mlen - 1 : mlen - 2;
        h = 0;
        for (int k = 1; k <= lim; k++) if (mx[k] == nx && my[k] == ny) h = 1;
        if (h) mdead = 1;
        else begin
          for (int i = MAXL - 1; i > 0; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
          end
          mx[0] = nx; my[0] = ny;
          if (g) begin
            if (mlen < MAXL) mlen++;
            mpend = 0;
          end
        end
      end else if (!mdead && GROW) mpend = 1;
      mcnt = (mcnt + 1) % T;
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge CLK) begin
    chk("head_x", HEAD_X, mx[0]);
    chk("head_y", HEAD_Y, my[0]);
    chk("length", LENGTH, mlen);
    chk("move_tick", MOVE_TICK, int'(RESET && mcnt == T - 1));
    chk("collision", COLLISION, mdead);
    chk("pixel_hit", PIXEL_HIT, epix);
    chk("head_hit", HEAD_HIT, ehead);
  end

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * T + 2 && !seen; i++) begin
      @(negedge CLK);
      seen = MOVE_TICK;
    end
    chk("tick_wait", seen, 1);
  endtask

  task automatic move(logic [1:0] d);
    DIR = d;
    wait_tick();
    @(posedge CLK); #1;
  endtask

  task automatic grow_at_tick(logic [1:0] d);
    DIR = d;
    wait_tick();
    GROW = 1;
    @(posedge CLK); #1;
    GROW = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET = 1;
    @(posedge CLK); #1 QUERY_Y = 64;
    @(negedge CLK);
    chk("q_tail_pix", PIXEL_HIT, 1);
    chk("q_tail_head", HEAD_HIT, 0);
    chk("tick_c1", MOVE_TICK, 0);
    @(posedge CLK); #1 QUERY_Y = 60;
    @(negedge CLK);
    chk("q_outside_pix", PIXEL_HIT, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("tick_c3", MOVE_TICK, 1);
    chk("q_head_pix", PIXEL_HIT, 1);
    chk("q_head_head", HEAD_HIT, 1);
    chk("head_y_pre", HEAD_Y, 60);
    @(posedge CLK); #1;
    chk("head_y_1", HEAD_Y, 59);
    chk("head_x_1", HEAD_X, 80);
    move(0);
    chk("head_y_2", HEAD_Y, 58);
    chk("len_init", LENGTH, 4);
    ENABLE = 0;
    repeat (12) @(posedge CLK);
    #1 chk("pause_head", HEAD_Y, 58);
    ENABLE = 1;
    move(0);
    chk("resume_head", HEAD_Y, 57);
    GROW = 1;
    @(posedge CLK); #1 GROW = 0;
    move(0);
    chk("grow_5", LENGTH, 5);
    QUERY_X = 80; QUERY_Y = 60;
    @(posedge CLK); #1;
    chk("tail_kept", PIXEL_HIT, 1);
    grow_at_tick(0);
    chk("grow_6", LENGTH, 6);
    do_reset();
    move(1); move(2); move(3);
    chk("tailfollow_col", COLLISION, 0);
    chk("tailfollow_x", HEAD_X, 80);
    chk("tailfollow_y", HEAD_Y, 61);
    do_reset();
    grow_at_tick(0);
    move(0); move(1); move(2);
    chk("pre_hit_col", COLLISION, 0);
    move(3);
    chk("hit_col", COLLISION, 1);
    chk("hit_x", HEAD_X, 81);
    chk("hit_y", HEAD_Y, 59);
    chk("hit_len", LENGTH, 5);
    GROW = 1;
    @(posedge CLK); #1 GROW = 0;
    repeat (12) @(posedge CLK);
    #1 chk("dead_x", HEAD_X, 81);
    chk("dead_len", LENGTH, 5);
    chk("dead_col", COLLISION, 1);
    @(posedge CLK); #2 RESET = 0;
    #1 chk("async_col", COLLISION, 0);
    chk("async_x", HEAD_X, 80);
    chk("async_y", HEAD_Y, 60);
    chk("async_len", LENGTH, 4);
    @(posedge CLK); #1 RESET = 1;
    for (int i = 0; i < 81; i++) move(3);
    chk("wrap_x", HEAD_X, 159);
    chk("wrap_x_y", HEAD_Y, 60);
    for (int i = 0; i < 61; i++) move(0);
    chk("wrap_y", HEAD_Y, 119);
    chk("wrap_y_x", HEAD_X, 159);
    for (int i = 0; i < 30; i++) grow_at_tick(0);
    chk("max_len", LENGTH, 32);
    chk("max_col", COLLISION, 0);
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK); #1;
      RESET = !(COLLISION && $urandom_range(0, 30) == 0) && $urandom_range(0, 400) != 0;
      if ($urandom_range(0, 3) == 0) DIR = 2'($urandom);
      ENABLE = $urandom_range(0, 9) != 0;
      GROW = $urandom_range(0, 6) == 0;
      if ($urandom_range(0, 1) == 0) begin
        QUERY_X = 8'(mx[0] + int'($urandom_range(0, 6)) - 3);
        QUERY_Y = 7'(my[0] + int'($urandom_range(0, 6)) - 3);
      end else begin
        QUERY_X = 8'($urandom_range(0, 255));
        QUERY_Y = 7'($urandom_range(0, 127));
      end
    end
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
